// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side handshake bundle for the cache controller.
// The slave view belongs to the controller: it serves the CPU and
// drives the memory request lines. The master view is the environment,
// meaning the CPU plus the memory behind it.
interface cache_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;

  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_hit;

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic                     mem_req_write;
  logic [ADDRESS_WIDTH-1:0] mem_req_addr;
  logic [DATA_WIDTH-1:0]    mem_req_wdata;
  logic                     mem_resp_valid;
  logic [DATA_WIDTH-1:0]    mem_resp_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// Set-associative, write-through, no-write-allocate cache controller.
// Read misses refill a whole line one word at a time, in word order.
// Victim selection: the lowest invalid way first, otherwise the set's
// round-robin pointer.
module cache_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SETS          = 256,
  parameter int WAYS          = 4,
  parameter int OFFSET_WIDTH  = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_ctrl_if.slave  bus
);

  localparam int SET_WIDTH  = $clog2(SETS);
  localparam int LANE_WIDTH = $clog2(DATA_WIDTH / 8);
  localparam int WORD_WIDTH = OFFSET_WIDTH - LANE_WIDTH;
  localparam int WORDS      = 1 << WORD_WIDTH;
  localparam int TAG_WIDTH  = ADDRESS_WIDTH - SET_WIDTH - OFFSET_WIDTH;
  localparam int WAY_WIDTH  = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Masks that clear the byte lane (word-aligned) or the whole line offset.
  localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK =
    ~ADDRESS_WIDTH'((DATA_WIDTH / 8) - 1);
  localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK =
    ~ADDRESS_WIDTH'((1 << OFFSET_WIDTH) - 1);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] LOOKUP      = 3'd1;
  localparam logic [2:0] REFILL_REQ  = 3'd2;
  localparam logic [2:0] REFILL_WAIT = 3'd3;
  localparam logic [2:0] WRITE_MEM   = 3'd4;
  localparam logic [2:0] RESP        = 3'd5;

  // Storage. Only the valid bits and the pointers are control state.
  logic [DATA_WIDTH-1:0]             data_mem [SETS][WAYS][WORDS];
  logic [TAG_WIDTH-1:0]              tag_mem  [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]         valid_q;
  logic [SETS-1:0][WAY_WIDTH-1:0]    rr_ptr;

  logic [2:0]                        state;
  logic [WORD_WIDTH-1:0]             beat;
  logic [WAY_WIDTH-1:0]              victim_p0;
  logic [DATA_WIDTH-1:0]             resp_rdata_q;
  logic                              resp_hit_q;

  // Request latched on acceptance.
  logic [ADDRESS_WIDTH-1:0]          addr_p0;
  logic                              write_p0;
  logic [DATA_WIDTH-1:0]             wdata_p0;

  logic [TAG_WIDTH-1:0]              tag_p0;
  logic [SET_WIDTH-1:0]              set_p0;
  logic [WORD_WIDTH-1:0]             word_p0;

  logic                              hit;
  logic [WAY_WIDTH-1:0]              hit_way;
  logic [WAY_WIDTH-1:0]              victim;
  logic                              all_valid;
  logic [WAY_WIDTH-1:0]              ptr_next;
  logic                              beat_last;
  logic [ADDRESS_WIDTH-1:0]          refill_addr;

  assign tag_p0  = addr_p0[ADDRESS_WIDTH-1 -: TAG_WIDTH];
  assign set_p0  = addr_p0[OFFSET_WIDTH +: SET_WIDTH];
  assign word_p0 = addr_p0[LANE_WIDTH +: WORD_WIDTH];

  assign beat_last   = (beat == WORD_WIDTH'(WORDS - 1));
  assign refill_addr = (addr_p0 & LINE_MASK) |
                       (ADDRESS_WIDTH'(beat) << LANE_WIDTH);
  assign all_valid   = &valid_q[set_p0];
  assign ptr_next    = (rr_ptr[set_p0] == WAY_WIDTH'(WAYS - 1)) ?
                       '0 : rr_ptr[set_p0] + 1'b1;

  // Tag compare across the ways of the latched set; at most one way can match.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set_p0][WAY_WIDTH'(w)] &&
          tag_mem[set_p0][WAY_WIDTH'(w)] == tag_p0) begin
        hit     = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the round-robin pointer.
  always_comb begin
    victim = rr_ptr[set_p0];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set_p0][WAY_WIDTH'(w)]) victim = WAY_WIDTH'(w);
    end
  end

  assign bus.req_ready     = (state == IDLE);
  assign bus.resp_valid    = (state == RESP);
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_hit      = resp_hit_q;
  assign bus.mem_req_valid = (state == REFILL_REQ) || (state == WRITE_MEM);
  assign bus.mem_req_write = (state == WRITE_MEM);
  assign bus.mem_req_addr  = (state == WRITE_MEM) ? (addr_p0 & WORD_MASK) :
                                                    refill_addr;
  assign bus.mem_req_wdata = wdata_p0;

  // Control FSM, valid bits, replacement pointers and the response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid_q      <= '0;
      rr_ptr       <= '0;
      beat         <= '0;
      victim_p0    <= '0;
      resp_rdata_q <= '0;
      resp_hit_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) state <= LOOKUP;
        end
        LOOKUP: begin
          if (write_p0) begin
            // The write goes through to memory whether it hit or missed.
            resp_hit_q   <= hit;
            resp_rdata_q <= '0;
            state        <= WRITE_MEM;
          end else if (hit) begin
            resp_hit_q   <= 1'b1;
            resp_rdata_q <= data_mem[set_p0][hit_way][word_p0];
            state        <= RESP;
          end else begin
            // Invalidate the victim now, so an abandoned refill never
            // leaves a half-written line marked valid.
            resp_hit_q                <= 1'b0;
            victim_p0                 <= victim;
            valid_q[set_p0][victim]   <= 1'b0;
            if (all_valid) rr_ptr[set_p0] <= ptr_next;
            beat                      <= '0;
            state                     <= REFILL_REQ;
          end
        end
        REFILL_REQ: begin
          if (bus.mem_req_ready) state <= REFILL_WAIT;
        end
        REFILL_WAIT: begin
          if (bus.mem_resp_valid) begin
            if (beat == word_p0) resp_rdata_q <= bus.mem_resp_rdata;
            if (beat_last) begin
              valid_q[set_p0][victim_p0] <= 1'b1;
              state                      <= RESP;
            end else begin
              beat  <= beat + 1'b1;
              state <= REFILL_REQ;
            end
          end
        end
        WRITE_MEM: begin
          if (bus.mem_req_ready) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request latch plus the data and tag arrays. None of these need a reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      addr_p0  <= bus.req_addr;
      write_p0 <= bus.req_write;
      wdata_p0 <= bus.req_wdata;
    end
    if (state == LOOKUP && write_p0 && hit) begin
      data_mem[set_p0][hit_way][word_p0] <= wdata_p0;
    end
    if (state == REFILL_WAIT && bus.mem_resp_valid) begin
      data_mem[set_p0][victim_p0][beat] <= bus.mem_resp_rdata;
      if (beat_last) tag_mem[set_p0][victim_p0] <= tag_p0;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl. The memory model returns each word's own
// address as its data; writes are recorded but not stored.
module tb_cache_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic rst_n;

  cache_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cache_ctrl #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SETS(256), .WAYS(4), .OFFSET_WIDTH(6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          rst_before;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          hit;
    logic [31:0] rdata;
    int          nrd;
    int          nwr;
    int          lat;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          stall_left = 0;
  int          mem_reads = 0;
  int          mem_writes = 0;
  logic [31:0] rd_log[$];
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  bit          resp_pending = 0;
  logic [31:0] resp_addr = '0;

  vec_t tbl[24];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Memory model: acts on the falling edge, so the controller samples it
  // on the next rising edge.
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = resp_pending;
      bus.mem_resp_rdata = resp_pending ? resp_addr : 32'h0;
      resp_pending       = 0;
      bus.mem_req_ready  = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready) begin
        if (bus.mem_req_write) begin
          mem_writes++;
          last_wr_addr = bus.mem_req_addr;
          last_wr_data = bus.mem_req_wdata;
        end else begin
          mem_reads++;
          rd_log.push_back(bus.mem_req_addr);
          resp_pending = 1;
          resp_addr    = bus.mem_req_addr;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    check("rst_req_ready",     bus.req_ready,     32'd1);
    check("rst_resp_valid",    bus.resp_valid,    32'd0);
    check("rst_mem_req_valid", bus.mem_req_valid, 32'd0);
    check("rst_resp_rdata",    bus.resp_rdata,    32'd0);
    check("rst_resp_hit",      bus.resp_hit,      32'd0);
  endtask

  task automatic do_req(input vec_t v, input string tag);
    int r0;
    int w0;
    int lat;
    bit ok;
    logic [31:0] base;
    @(negedge clk); #1;
    check({tag, "_req_ready"}, bus.req_ready, 32'd1);
    r0 = mem_reads;
    w0 = mem_writes;
    rd_log.delete();
    bus.req_valid = 1'b1;
    bus.req_write = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    @(negedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 200) begin
      @(negedge clk); #1;
      lat++;
    end
    if (bus.resp_valid !== 1'b1) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got no resp_valid, expected one within 200 cycles", tag);
      return;
    end
    check({tag, "_hit"},   bus.resp_hit,   32'(v.hit));
    check({tag, "_rdata"}, bus.resp_rdata, v.rdata);
    check({tag, "_nrd"},   mem_reads - r0, v.nrd);
    check({tag, "_nwr"},   mem_writes - w0, v.nwr);
    if (v.lat != 0) check({tag, "_latency"}, lat, v.lat);
    if (v.wr) begin
      check({tag, "_wr_addr"}, last_wr_addr, v.addr & 32'hFFFF_FFFC);
      check({tag, "_wr_data"}, last_wr_data, v.wdata);
    end
    if (v.nrd == 16) begin
      base = v.addr & 32'hFFFF_FFC0;
      ok   = (rd_log.size() == 16);
      for (int i = 0; i < rd_log.size(); i++)
        if (rd_log[i] !== base + 32'(4 * i)) ok = 0;
      check({tag, "_refill_order"}, 32'(ok), 32'd1);
    end
    @(negedge clk); #1;
    check({tag, "_resp_pulse"}, bus.resp_valid, 32'd0);
  endtask

  initial begin
    int   c;
    int   stalled;
    bit   stable_ok;
    bit   quiet;
    vec_t v;

    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    //          rst wr  addr           wdata          hit rdata          nrd nwr lat
    tbl[0]  = '{1, 0, 32'h0000_1004, 32'h0,         0, 32'h0000_1004, 16, 0, 0};
    tbl[1]  = '{0, 0, 32'h0000_1004, 32'h0,         1, 32'h0000_1004,  0, 0, 2};
    tbl[2]  = '{0, 0, 32'h0000_103C, 32'h0,         1, 32'h0000_103C,  0, 0, 2};
    tbl[3]  = '{0, 1, 32'h0000_1008, 32'hDEAD_BEEF, 1, 32'h0,          0, 1, 0};
    tbl[4]  = '{0, 0, 32'h0000_1008, 32'h0,         1, 32'hDEAD_BEEF,  0, 0, 2};
    tbl[5]  = '{0, 1, 32'h0000_8000, 32'h1234_5678, 0, 32'h0,          0, 1, 0};
    tbl[6]  = '{0, 0, 32'h0000_8000, 32'h0,         0, 32'h0000_8000, 16, 0, 0};
    tbl[7]  = '{0, 1, 32'h0000_100B, 32'h0000_5555, 1, 32'h0,          0, 1, 0};
    tbl[8]  = '{0, 0, 32'h0000_1009, 32'h0,         1, 32'h0000_5555,  0, 0, 2};
    // Set 0, tags 0..4: the fifth line evicts way 0.
    tbl[9]  = '{1, 0, 32'h0000_0000, 32'h0,         0, 32'h0000_0000, 16, 0, 0};
    tbl[10] = '{0, 0, 32'h0000_4004, 32'h0,         0, 32'h0000_4004, 16, 0, 0};
    tbl[11] = '{0, 0, 32'h0000_8008, 32'h0,         0, 32'h0000_8008, 16, 0, 0};
    tbl[12] = '{0, 0, 32'h0000_C00C, 32'h0,         0, 32'h0000_C00C, 16, 0, 0};
    tbl[13] = '{0, 0, 32'h0001_0000, 32'h0,         0, 32'h0001_0000, 16, 0, 0};
    tbl[14] = '{0, 0, 32'h0000_4004, 32'h0,         1, 32'h0000_4004,  0, 0, 2};
    tbl[15] = '{0, 0, 32'h0000_8008, 32'h0,         1, 32'h0000_8008,  0, 0, 2};
    tbl[16] = '{0, 0, 32'h0000_0000, 32'h0,         0, 32'h0000_0000, 16, 0, 0};
    tbl[17] = '{0, 0, 32'h0001_0000, 32'h0,         1, 32'h0001_0000,  0, 0, 2};
    tbl[18] = '{0, 0, 32'h0000_4004, 32'h0,         0, 32'h0000_4004, 16, 0, 0};
    // A write miss must leave the pointer at way 3.
    tbl[19] = '{0, 1, 32'h0001_4000, 32'h0000_AAAA, 0, 32'h0,          0, 1, 0};
    tbl[20] = '{0, 0, 32'h0001_0000, 32'h0,         1, 32'h0001_0000,  0, 0, 2};
    tbl[21] = '{0, 0, 32'h0000_C00C, 32'h0,         1, 32'h0000_C00C,  0, 0, 2};
    tbl[22] = '{0, 0, 32'h0001_8000, 32'h0,         0, 32'h0001_8000, 16, 0, 0};
    tbl[23] = '{0, 0, 32'h0000_C00C, 32'h0,         0, 32'h0000_C00C, 16, 0, 0};

    for (int i = 0; i < 24; i++) begin
      if (tbl[i].rst_before) do_reset();
      do_req(tbl[i], $sformatf("v%0d", i));
    end

    // Refill stalled by memory, then reset in the middle of beat 7.
    do_reset();
    stall_left = 12;
    @(negedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_2000;
    bus.req_wdata = '0;
    @(negedge clk); #1;
    bus.req_valid = 1'b0;
    stalled   = 0;
    stable_ok = 1;
    for (int k = 0; k < 14; k++) begin
      if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready === 1'b0) begin
        stalled++;
        if (bus.mem_req_addr !== 32'h0000_2000 || bus.mem_req_write !== 1'b0)
          stable_ok = 0;
      end
      @(negedge clk); #1;
    end
    check("stall_cycles_ge_10", 32'(stalled >= 10), 32'd1);
    check("stall_addr_stable",  32'(stable_ok),     32'd1);

    c = 0;
    while (!(bus.mem_req_valid === 1'b1 && bus.mem_req_addr === 32'h0000_201C) && c < 200) begin
      @(negedge clk); #1;
      c++;
    end
    check("beat7_reached", 32'(c < 200), 32'd1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    check("midrst_req_ready",     bus.req_ready,     32'd1);
    check("midrst_mem_req_valid", bus.mem_req_valid, 32'd0);
    check("midrst_resp_valid",    bus.resp_valid,    32'd0);
    quiet = 1;
    for (int k = 0; k < 20; k++) begin
      if (bus.resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) quiet = 0;
      @(negedge clk); #1;
    end
    check("midrst_no_response", 32'(quiet), 32'd1);

    v = '{0, 0, 32'h0000_2004, 32'h0, 0, 32'h0000_2004, 16, 0, 0};
    do_req(v, "reread_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
